// File: rtl/axi_txn_arbiter.sv
// Two-requester round-robin arbiter that serialises block transactions onto an AXI4-Lite master.
// Optional watchdog on the ISSUE phase is enabled with `define ARB_TIMEOUT_EN.
module axi_txn_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [1:0]            req0_mode,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    input  logic [1:0]            req1_mode,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  req0_done,
    output logic                  req1_done,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            m_mode,
    output logic [ADDR_WIDTH-1:0] m_addra,
    output logic [ADDR_WIDTH-1:0] m_addrb,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_txn_en,
    input  logic                  m_inst_done,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   ptr;
    logic   gnt_id;
    logic   illegal;
    logic   is_load;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] issue_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Handshake: a requester holds valid and its fields stable until it sees a one-cycle
    // ready pulse; the matching done pulse (with rsp_err/rsp_rdata) follows later.
    // A valid withdrawn before ready was never seen and is simply not served.
    logic                  grant_valid;
    logic                  grant_sel;
    logic [1:0]            sel_mode;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_legal;

    always_comb begin
        grant_valid = (req0_valid || req1_valid) && !m_inst_done;
        grant_sel   = (req0_valid && req1_valid) ? ptr : req1_valid;
        sel_mode    = grant_sel ? req1_mode  : req0_mode;
        sel_addr    = grant_sel ? req1_addr  : req0_addr;
        sel_wdata   = grant_sel ? req1_wdata : req0_wdata;
        sel_legal   = (sel_mode == MODE_LOAD) || (sel_mode == MODE_WRITE);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            gnt_id     <= 1'b0;
            illegal    <= 1'b0;
            is_load    <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            m_mode     <= '0;
            m_addra    <= '0;
            m_addrb    <= '0;
            m_wdata    <= '0;
            m_txn_en   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            issue_cnt  <= '0;
`endif
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            rsp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_id     <= grant_sel;
                        req0_ready <= !grant_sel;
                        req1_ready <= grant_sel;
                        m_mode     <= sel_mode;
                        m_addra    <= (sel_mode == MODE_WRITE) ? sel_addr : '0;
                        m_addrb    <= (sel_mode == MODE_LOAD)  ? sel_addr : '0;
                        m_wdata    <= sel_wdata;
                        m_txn_en   <= sel_legal;
                        illegal    <= !sel_legal;
                        is_load    <= (sel_mode == MODE_LOAD);
`ifdef ARB_TIMEOUT_EN
                        issue_cnt  <= '0;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal modes never reach the master, so there is no RELEASE handshake.
                    if (illegal) begin
                        req0_done <= !gnt_id;
                        req1_done <= gnt_id;
                        rsp_err   <= 1'b1;
                        ptr       <= ~gnt_id;
                        state     <= IDLE;
                    end else if (m_inst_done) begin
                        m_txn_en  <= 1'b0;
                        if (is_load) rsp_rdata <= m_rdata;
                        req0_done <= !gnt_id;
                        req1_done <= gnt_id;
                        state     <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (issue_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        m_txn_en  <= 1'b0;
                        req0_done <= !gnt_id;
                        req1_done <= gnt_id;
                        rsp_err   <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!m_inst_done) begin
                        ptr   <= ~gnt_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Directed bench for axi_txn_arbiter: outputs sampled on the falling edge, inputs driven there too.
module tb_axi_txn_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req1_valid;
    logic [1:0]   req0_mode, req1_mode;
    logic [31:0]  req0_addr, req1_addr;
    logic [127:0] req0_wdata, req1_wdata;
    logic         req0_ready, req1_ready, req0_done, req1_done, rsp_err;
    logic [127:0] rsp_rdata;
    logic [1:0]   m_mode;
    logic [31:0]  m_addra, m_addrb;
    logic [127:0] m_wdata;
    logic         m_txn_en;
    logic         m_inst_done;
    logic [127:0] m_rdata;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_txn_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req0_ready(req0_ready), .req1_ready(req1_ready), .req0_done(req0_done), .req1_done(req1_done),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .m_mode(m_mode), .m_addra(m_addra), .m_addrb(m_addrb), .m_wdata(m_wdata), .m_txn_en(m_txn_en),
        .m_inst_done(m_inst_done), .m_rdata(m_rdata), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 0; req0_mode = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_mode = 0; req1_addr = 0; req1_wdata = 0;
        m_inst_done = 0; m_rdata = 0;
        repeat (2) tick();
        check("rst_state", state_dbg, 0);
        check("rst_txn_en", m_txn_en, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_done", {req0_done, req1_done}, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_fields", {m_mode, m_addra, m_addrb}, 0);
        check("rst_wdata", m_wdata, 0);
        reset_n = 1'b1;

        // req1 write, master finishes after 5 cycles of m_txn_en
        req1_valid = 1; req1_mode = 2'b10; req1_addr = 32'h10; req1_wdata = 128'h100;
        tick();
        check("w_ready1", req1_ready, 1);
        check("w_ready0", req0_ready, 0);
        check("w_txn_en", m_txn_en, 1);
        check("w_addra", m_addra, 32'h10);
        check("w_addrb", m_addrb, 0);
        check("w_wdata", m_wdata, 128'h100);
        check("w_mode", m_mode, 2'b10);
        check("w_state", state_dbg, 1);
        req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("w_hold_txn", m_txn_en, 1);
            check("w_hold_ready", req1_ready, 0);
            check("w_hold_done", req1_done, 0);
        end
        m_inst_done = 1;
        tick();
        check("w_done1", req1_done, 1);
        check("w_err", rsp_err, 0);
        check("w_txn_off", m_txn_en, 0);
        check("w_release", state_dbg, 2);
        m_inst_done = 0;
        tick();
        check("w_done_pulse", req1_done, 0);
        check("w_idle", state_dbg, 0);

        // req0 load returning 0xDEADBEEF
        req0_valid = 1; req0_mode = 2'b01; req0_addr = 32'h20;
        tick();
        check("l_ready0", req0_ready, 1);
        check("l_addrb", m_addrb, 32'h20);
        check("l_addra", m_addra, 0);
        check("l_mode", m_mode, 2'b01);
        check("l_txn_en", m_txn_en, 1);
        req0_valid = 0; m_inst_done = 1; m_rdata = 128'hDEADBEEF;
        tick();
        check("l_done0", req0_done, 1);
        check("l_rdata", rsp_rdata, 128'hDEADBEEF);
        check("l_err", rsp_err, 0);
        m_inst_done = 0; m_rdata = 0;
        tick();
        check("l_idle", state_dbg, 0);

        // a write must leave rsp_rdata untouched
        req1_valid = 1; req1_mode = 2'b10; req1_addr = 32'h40; req1_wdata = 128'h44;
        tick();
        check("w2_ready1", req1_ready, 1);
        req1_valid = 0; m_inst_done = 1; m_rdata = 128'h55;
        tick();
        check("w2_done1", req1_done, 1);
        check("w2_rdata_kept", rsp_rdata, 128'hDEADBEEF);
        m_inst_done = 0; m_rdata = 0;
        tick();

        // fresh reset, then both requesters valid continuously: grants 0,1,0,1
        reset_n = 0;
        #1;
        check("rr_rst_rdata", rsp_rdata, 0);
        tick();
        reset_n = 1;
        req0_valid = 1; req0_mode = 2'b10; req0_addr = 32'hA0; req0_wdata = 128'hA;
        req1_valid = 1; req1_mode = 2'b10; req1_addr = 32'hB0; req1_wdata = 128'hB;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = (i % 2) == 1;
            tick();
            check("rr_ready0", req0_ready, !g);
            check("rr_ready1", req1_ready, g);
            check("rr_txn_en", m_txn_en, 1);
            check("rr_addra", m_addra, g ? 32'hB0 : 32'hA0);
            check("rr_wdata", m_wdata, g ? 128'hB : 128'hA);
            m_inst_done = 1;
            tick();
            check("rr_done0", req0_done, !g);
            check("rr_done1", req1_done, g);
            check("rr_txn_off", m_txn_en, 0);
            m_inst_done = 0;
            tick();
            check("rr_idle", state_dbg, 0);
            check("rr_no_ready", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 0; req1_valid = 0;
        check("rr_rdata_zero", rsp_rdata, 0);

        // illegal modes: 2'b11 on req0, 2'b00 on req1
        req0_valid = 1; req0_mode = 2'b11; req0_addr = 32'h30;
        tick();
        check("ill0_ready", req0_ready, 1);
        check("ill0_txn_en", m_txn_en, 0);
        check("ill0_state", state_dbg, 1);
        req0_valid = 0;
        tick();
        check("ill0_done", req0_done, 1);
        check("ill0_err", rsp_err, 1);
        check("ill0_txn_en2", m_txn_en, 0);
        check("ill0_idle", state_dbg, 0);
        tick();
        check("ill0_done_off", req0_done, 0);
        check("ill0_err_off", rsp_err, 0);
        req1_valid = 1; req1_mode = 2'b00; req1_addr = 32'h34;
        tick();
        check("ill1_ready", req1_ready, 1);
        check("ill1_txn_en", m_txn_en, 0);
        req1_valid = 0;
        tick();
        check("ill1_done", req1_done, 1);
        check("ill1_err", rsp_err, 1);
        tick();

        // reset during ISSUE, then a stale m_inst_done blocks new grants
        req0_valid = 1; req0_mode = 2'b10; req0_addr = 32'h50; req0_wdata = 128'h5;
        tick();
        check("ab_txn_en", m_txn_en, 1);
        req0_valid = 0; reset_n = 0; m_inst_done = 1;
        #1;
        check("ab_txn_off", m_txn_en, 0);
        check("ab_state", state_dbg, 0);
        check("ab_addra", m_addra, 0);
        tick();
        reset_n = 1;
        req0_valid = 1; req0_mode = 2'b10; req0_addr = 32'h60; req0_wdata = 128'h6;
        req1_valid = 1; req1_mode = 2'b10; req1_addr = 32'h70; req1_wdata = 128'h7;
        tick();
        check("st_no_ready", {req0_ready, req1_ready}, 0);
        check("st_no_done", {req0_done, req1_done}, 0);
        check("st_idle", state_dbg, 0);
        req1_valid = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("st_hold_ready", {req0_ready, req1_ready}, 0);
            check("st_hold_idle", state_dbg, 0);
        end
        m_inst_done = 0;
        tick();
        check("st_ready0", req0_ready, 1);
        check("st_ready1", req1_ready, 0);
        check("st_addra", m_addra, 32'h60);
        req0_valid = 0; m_inst_done = 1;
        tick();
        check("st_done0", req0_done, 1);
        m_inst_done = 0;
        tick();
        check("st_idle2", state_dbg, 0);

        // master never answers: watchdog (if built in) fires after 8 ISSUE cycles
        req1_valid = 1; req1_mode = 2'b10; req1_addr = 32'h80; req1_wdata = 128'h8;
        tick();
        check("to_ready1", req1_ready, 1);
        req1_valid = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            check("to_wait_txn", m_txn_en, 1);
            check("to_wait_done", req1_done, 0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_done1", req1_done, 1);
        check("to_err", rsp_err, 1);
        check("to_txn_off", m_txn_en, 0);
        check("to_release", state_dbg, 2);
`else
        check("nto_txn_en", m_txn_en, 1);
        check("nto_no_done", req1_done, 0);
        check("nto_state", state_dbg, 1);
        m_inst_done = 1;
        tick();
        check("nto_done1", req1_done, 1);
        check("nto_err", rsp_err, 0);
        m_inst_done = 0;
`endif
        tick();
        check("to_idle", state_dbg, 0);
        check("to_err_off", rsp_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_txn_arbiter.md
AXI_TXN_ARBITER -- requirements
Module: axi_txn_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of offset-memory addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, width of one block payload (4 x 32-bit AXI beats).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with ARB_TIMEOUT_EN).
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Ports req0_valid / req1_valid  input  1  requester 0 (load unit) / requester 1 (write-back unit) holds a request.
REQ-007 Ports req0_mode / req1_mode  input  2  2'b01 LOAD_DATA, 2'b10 WRITE_DATA; 2'b00 and 2'b11 are illegal.
REQ-008 Ports req0_addr / req1_addr  input  ADDR_WIDTH  offset-memory address.
REQ-009 Ports req0_wdata / req1_wdata  input  DATA_WIDTH  write payload.
REQ-010 Ports req0_ready / req1_ready  output  1  one-cycle pulse: request accepted.
REQ-011 Ports req0_done / req1_done  output  1  one-cycle pulse: request finished.
REQ-012 Port rsp_err  output  1  valid with a done pulse: 1 = illegal mode or timeout.
REQ-013 Port rsp_rdata  output  DATA_WIDTH  load result, valid with done of a LOAD_DATA request.
REQ-014 Ports m_mode (2), m_addra (ADDR_WIDTH), m_addrb (ADDR_WIDTH), m_wdata (DATA_WIDTH), m_txn_en (1)  output  drive the AXI4-Lite master.
REQ-015 Ports m_inst_done (1), m_rdata (DATA_WIDTH)  input  from the AXI4-Lite master.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RELEASE, with registered outputs only.
REQ-017 IDLE: SHALL grant only when m_inst_done is 0; a stale m_inst_done=1 holds the FSM in IDLE.
REQ-018 Both valid in the same IDLE cycle: SHALL grant the requester selected by a 1-bit round-robin pointer (reset 0); a single valid requester is granted regardless of the pointer.
REQ-019 On grant at edge t, SHALL capture mode/addr/wdata, pulse reqN_ready in cycle t+1, and assert m_txn_en in cycle t+1 (state ISSUE).
REQ-020 LOAD_DATA: SHALL drive captured addr on m_addrb, m_addra=0; WRITE_DATA: captured addr on m_addra, m_addrb=0; m_wdata = captured wdata.
REQ-021 Illegal mode: SHALL pulse ready, then done with rsp_err=1 in the next cycle, never raise m_txn_en, and return to IDLE.
REQ-022 ISSUE: SHALL hold m_txn_en=1 and the captured fields stable until m_inst_done is sampled 1.
REQ-023 On m_inst_done=1 in ISSUE: SHALL clear m_txn_en, capture m_rdata into rsp_rdata (LOAD_DATA only; unchanged for WRITE_DATA), pulse reqN_done with rsp_err=0 the next cycle, enter RELEASE.
REQ-024 RELEASE: SHALL wait for m_inst_done=0, then enter IDLE and set the pointer to the non-granted requester.
REQ-025 Requesters SHALL keep valid and fields stable until ready; a valid dropped before grant is ignored.
REQ-026 Back-to-back: minimum request-to-request spacing SHALL be IDLE -> ISSUE -> RELEASE -> IDLE with no extra idle cycle.

Reset
REQ-027 On reset_n=0, SHALL immediately force state IDLE, pointer 0, m_txn_en=0, m_mode=0, m_addra=0, m_addrb=0, m_wdata=0, all ready/done=0, rsp_err=0, rsp_rdata=0.
REQ-028 Reset mid-ISSUE SHALL abort silently, without a done pulse; after release the FSM obeys REQ-017 before any new grant.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: SHALL count ISSUE cycles; reaching TIMEOUT_CYCLES without m_inst_done SHALL clear m_txn_en, pulse done with rsp_err=1, and enter RELEASE.
REQ-030 Macro ARB_TIMEOUT_EN undefined: no counter; ISSUE waits indefinitely and rsp_err is set only by illegal mode.

Verification
REQ-031 req1 WRITE_DATA addr 0x10, wdata 0x100; master done after 5 cycles -> m_txn_en=1, m_addra=0x10, m_wdata=0x100, req1_done, rsp_err=0.
REQ-032 req0 LOAD_DATA addr 0x20, m_rdata 0xDEADBEEF -> m_addrb=0x20, req0_done, rsp_rdata=0xDEADBEEF.
REQ-033 Both valid continuously after reset -> grants 0,1,0,1; at most one m_txn_en session at a time.
REQ-034 req0 mode 2'b11 -> req0_ready, then req0_done with rsp_err=1; m_txn_en stays 0.
REQ-035 reset_n pulsed low during ISSUE -> m_txn_en=0 immediately, no done; with m_inst_done stuck 1, no new grant.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_inst_done never set -> after 8 ISSUE cycles done pulse with rsp_err=1, m_txn_en=0.
